// File: rtl/fp32_serial_mul.sv
// Serial-load binary32 multiplier.
// Each operand arrives as BUS_W-bit beats, most-significant beat first: A, then B.
// The product is formed in one cycle (MUL), then normalised, rounded and
// classified in a second cycle (NORM). The result is returned on dataOut/err
// together with a one-cycle r_o pulse.
module fp32_serial_mul #(
  parameter int BUS_W    = 16,
  parameter bit ROUND_NE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             R_I,
  input  logic [BUS_W-1:0] dataIn,
  output logic [31:0]      dataOut,
  output logic             r_o,
  output logic [1:0]       err,
  output logic             busy
);

  localparam int         NBEATS    = 32 / BUS_W;
  localparam logic [2:0] LAST_BEAT = 3'(NBEATS - 1);

  typedef enum logic [1:0] {LDA, LDB, MUL, NORM} state_t;

  state_t      state;
  logic [2:0]  beat_cnt;
  logic [31:0] opa, opb;
  logic [31:0] opa_shift, opb_shift;

  // MUL -> NORM stage registers
  logic               sign_p1;
  logic signed [9:0]  exp_p1;
  logic [47:0]        prod_p1;
  logic               nan_p1, inf_p1, zero_p1;

  // NORM stage combinational result
  logic [32:0]        nr_p2;
  logic signed [9:0]  fin_exp_p2;
  logic [31:0]        res_p2;
  logic [1:0]         err_p2;

  // Operand field decode
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  // Beat shifting; a full-width bus simply replaces the operand
  generate
    if (BUS_W == 32) begin : g_full
      assign opa_shift = dataIn;
      assign opb_shift = dataIn;
    end else begin : g_narrow
      assign opa_shift = {opa[31-BUS_W:0], dataIn};
      assign opb_shift = {opb[31-BUS_W:0], dataIn};
    end
  endgenerate

  assign ea     = opa[30:23];
  assign eb     = opb[30:23];
  assign ma     = opa[22:0];
  assign mb     = opb[22:0];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (ma == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (mb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (ma != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (mb != 23'd0);

  // Normalise the 48-bit product and round; returns {exp[9:0], mantissa[22:0]}.
  // A rounding carry out of the mantissa leaves an all-zero fraction and bumps exp.
  function automatic logic [32:0] norm_round(input logic [47:0] p,
                                             input logic signed [9:0] e);
    logic [22:0]       m;
    logic              g, s, up;
    logic signed [9:0] x;
    logic [23:0]       r;
    if (p[47]) begin
      m = p[46:24];
      g = p[23];
      s = |p[22:0];
      x = e + 10'sd1;
    end else begin
      m = p[45:23];
      g = p[22];
      s = |p[21:0];
      x = e;
    end
    up = ROUND_NE && g && (s || m[0]);
    r  = {1'b0, m} + {23'd0, up};
    if (r[23]) x = x + 10'sd1;
    return {x, r[22:0]};
  endfunction

  // Classify the NORM-stage result; special operands take priority over range checks
  always_comb begin
    nr_p2      = norm_round(prod_p1, exp_p1);
    fin_exp_p2 = nr_p2[32:23];
    res_p2     = {sign_p1, fin_exp_p2[7:0], nr_p2[22:0]};
    err_p2     = 2'b00;
    if (nan_p1) begin
      res_p2 = 32'h7FC0_0000;
      err_p2 = 2'b11;
    end else if (inf_p1) begin
      res_p2 = {sign_p1, 8'hFF, 23'd0};
      err_p2 = 2'b01;
    end else if (zero_p1) begin
      res_p2 = {sign_p1, 31'd0};
      err_p2 = 2'b00;
    end else if (fin_exp_p2 >= 10'sd255) begin
      res_p2 = {sign_p1, 8'hFF, 23'd0};
      err_p2 = 2'b01;
    end else if (fin_exp_p2 <= 10'sd0) begin
      res_p2 = {sign_p1, 31'd0};
      err_p2 = 2'b10;
    end
  end

  // Control FSM with operand loading, product stage and registered result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= LDA;
      beat_cnt <= 3'd0;
      opa      <= 32'd0;
      opb      <= 32'd0;
      sign_p1  <= 1'b0;
      exp_p1   <= 10'sd0;
      prod_p1  <= 48'd0;
      nan_p1   <= 1'b0;
      inf_p1   <= 1'b0;
      zero_p1  <= 1'b0;
      dataOut  <= 32'd0;
      err      <= 2'b00;
      r_o      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      r_o <= 1'b0;
      case (state)
        LDA: begin
          if (R_I && !busy) begin
            opa <= opa_shift;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= 3'd0;
              state    <= LDB;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end
        LDB: begin
          if (R_I && !busy) begin
            opb <= opb_shift;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= 3'd0;
              state    <= MUL;
              busy     <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end
        // ---- stage p1: mantissa product, exponent sum, special-case flags
        MUL: begin
          prod_p1 <= 48'({1'b1, ma}) * 48'({1'b1, mb});
          exp_p1  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
          sign_p1 <= opa[31] ^ opb[31];
          nan_p1  <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
          inf_p1  <= a_inf || b_inf;
          zero_p1 <= a_zero || b_zero;
          state   <= NORM;
        end
        // ---- stage p2: normalised, rounded, classified result
        NORM: begin
          dataOut <= res_p2;
          err     <= err_p2;
          r_o     <= 1'b1;
          busy    <= 1'b0;
          state   <= LDA;
        end
        default: state <= LDA;
      endcase
    end
  end

endmodule
